// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// A prescaler divides clk into digit slots. Each slot drives one active-low
// anode and the decoded segments of that digit's nibble from a shadow register.
// New data is staged in a pending register and committed at frame boundaries,
// so a frame never shows a mix of old and new digits.
// Optional feature: define SEG_SCAN_LZ_BLANK_EN to blank leading zero digits.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        ready,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          wrap;
    logic [15:0]   shadow;
    logic [15:0]   pending;
    logic          ready_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic [3:0]    nib;
    logic          lz_blank;

    // Hex nibble to {a,b,c,d,e,f,g}, active-high.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state follows en; slot tick and frame wrap only exist while scanning.
    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = SCAN;
            end
            SCAN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    tick = (cnt == CNT_MAX);
                    wrap = tick && (idx == 2'd3);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler and digit index; both cleared whenever we are (or are going) idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (state_nxt == IDLE) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Select the current digit's nibble and work out leading-zero blanking.
    always_comb begin
        nib      = shadow[idx*4 +: 4];
        lz_blank = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        case (idx)
            2'd3:    lz_blank = (shadow[15:12] == 4'h0);
            2'd2:    lz_blank = (shadow[15:8]  == 8'h00);
            2'd1:    lz_blank = (shadow[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    // Registered anode/segment drive; blank as soon as we head back to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h00;
        end else if (state_nxt == IDLE) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h00;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= lz_blank ? 7'h00 : decode(nib);
        end
    end

    // Load handshake: direct shadow write when idle, staged commit at frame wrap
    // or on leaving the scan state while scanning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= 16'h0000;
            pending <= 16'h0000;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load && ready_q) shadow <= data_in;
                    ready_q <= 1'b1;
                end
                SCAN: begin
                    if (!en) begin
                        if (!ready_q)  shadow <= pending;
                        else if (load) shadow <= data_in;
                        ready_q <= 1'b1;
                    end else if (wrap) begin
                        if (!ready_q) begin
                            shadow  <= pending;
                            ready_q <= 1'b1;
                        end else if (load) begin
                            pending <= data_in;
                            ready_q <= 1'b0;
                        end
                    end else if (load && ready_q) begin
                        pending <= data_in;
                        ready_q <= 1'b0;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign ready = ready_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed test of seg_scan_ctrl with CLK_DIV=4.
// Outputs are sampled 1 time unit after each rising edge. Each digit slot is
// 4 cycles long; after entering the scan state, the first 4 samples show digit 0.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] data_in;
    logic        load;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam logic [6:0] Z_HI = 7'h00;
`else
    localparam logic [6:0] Z_HI = 7'h7E;
`endif

    seg_scan_ctrl #(.CLK_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .data_in (data_in),
        .load    (load),
        .ready   (ready),
        .seg     (seg),
        .an      (an)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [15:0] d);
        rst_n   = r;
        en      = e;
        load    = l;
        data_in = d;
    endtask

    task automatic steps(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic rdy_e);
        checks++;
        assert (an === an_e) else begin
            errors++;
            $error("[TB] FAIL %s an: got %b expected %b", tag, an, an_e);
        end
        checks++;
        assert (seg === seg_e) else begin
            errors++;
            $error("[TB] FAIL %s seg: got %h expected %h", tag, seg, seg_e);
        end
        checks++;
        assert (ready === rdy_e) else begin
            errors++;
            $error("[TB] FAIL %s ready: got %b expected %b", tag, ready, rdy_e);
        end
    endtask

    // Directed sequence.
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        steps(1);
        checkOutput("reset", 4'b1111, 7'h00, 1'b1);

        // Blank shadow scan after reset.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("rst_d0_first", 4'b1110, 7'h7E, 1'b1);
        steps(3);  checkOutput("rst_d0_last",  4'b1110, 7'h7E, 1'b1);
        steps(1);  checkOutput("rst_d1",       4'b1101, Z_HI,  1'b1);
        steps(4);  checkOutput("rst_d2",       4'b1011, Z_HI,  1'b1);
        steps(4);  checkOutput("rst_d3",       4'b0111, Z_HI,  1'b1);
        steps(4);  checkOutput("rst_d0_again", 4'b1110, 7'h7E, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        steps(1);  checkOutput("to_idle",      4'b1111, 7'h00, 1'b1);

        // Idle load goes straight to shadow.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234);
        steps(1);  checkOutput("idle_load",    4'b1111, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("1234_d0",      4'b1110, 7'h33, 1'b1);
        steps(4);  checkOutput("1234_d1",      4'b1101, 7'h79, 1'b1);
        steps(4);  checkOutput("1234_d2",      4'b1011, 7'h6D, 1'b1);
        steps(4);  checkOutput("1234_d3",      4'b0111, 7'h30, 1'b1);
        steps(4);  checkOutput("1234_d0_again",4'b1110, 7'h33, 1'b1);

        // Mid-frame load at idx=1, second load ignored, commit at wrap.
        steps(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hABCD);
        steps(1);  checkOutput("abcd_accept",  4'b1101, 7'h79, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000);
        steps(1);  checkOutput("second_load",  4'b1101, 7'h79, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(9);  checkOutput("pre_wrap",     4'b0111, 7'h30, 1'b0);
        steps(1);  checkOutput("wrap_commit",  4'b0111, 7'h30, 1'b1);
        steps(1);  checkOutput("abcd_d0",      4'b1110, 7'h3D, 1'b1);
        steps(4);  checkOutput("abcd_d1",      4'b1101, 7'h4E, 1'b1);
        steps(4);  checkOutput("abcd_d2",      4'b1011, 7'h1F, 1'b1);
        steps(4);  checkOutput("abcd_d3",      4'b0111, 7'h77, 1'b1);

        // Load on the wrap cycle while ready: captured, committed next wrap.
        steps(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h5678);
        steps(1);  checkOutput("wrap_load_rdy",4'b0111, 7'h77, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("no_mid_commit",4'b1110, 7'h3D, 1'b0);
        steps(15); checkOutput("wrap2_commit", 4'b0111, 7'h77, 1'b1);
        steps(1);  checkOutput("5678_d0",      4'b1110, 7'h7F, 1'b1);

        // Load on the wrap cycle while busy: pending commits, new load dropped.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h9ABC);
        steps(1);  checkOutput("9abc_accept",  4'b1110, 7'h7F, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(13); checkOutput("5678_d3",      4'b0111, 7'h5B, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111);
        steps(1);  checkOutput("wrap_load_busy",4'b0111, 7'h5B, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("9abc_d0",      4'b1110, 7'h4E, 1'b1);

        // Drop en at idx=2 with pending outstanding.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h2468);
        steps(1);  checkOutput("2468_accept",  4'b1110, 7'h4E, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(6);  checkOutput("at_idx2",      4'b1101, 7'h1F, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        steps(1);  checkOutput("exit_commit",  4'b1111, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("2468_d0",      4'b1110, 7'h7F, 1'b1);
        steps(3);  checkOutput("2468_d0_last", 4'b1110, 7'h7F, 1'b1);
        steps(1);  checkOutput("2468_d1",      4'b1101, 7'h5F, 1'b1);

        // Reset mid-frame with pending outstanding, en and load held high.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h7777);
        steps(1);  checkOutput("7777_accept",  4'b1101, 7'h5F, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
        steps(1);  checkOutput("mid_reset",    4'b1111, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        steps(1);  checkOutput("post_reset",   4'b1111, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("clr_d0",       4'b1110, 7'h7E, 1'b1);
        steps(4);  checkOutput("clr_d1",       4'b1101, Z_HI,  1'b1);

        // Leading-zero pattern 0F00.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        steps(1);  checkOutput("idle_again",   4'b1111, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0F00);
        steps(1);  checkOutput("0f00_load",    4'b1111, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        steps(1);  checkOutput("0f00_d0",      4'b1110, 7'h7E, 1'b1);
        steps(4);  checkOutput("0f00_d1",      4'b1101, 7'h7E, 1'b1);
        steps(4);  checkOutput("0f00_d2",      4'b1011, 7'h47, 1'b1);
        steps(4);  checkOutput("0f00_d3",      4'b0111, Z_HI,  1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 en  in  1  scan enable; 0 blanks display.
REQ-005 data_in  in  16  four hex nibbles; [3:0]=digit0 ... [15:12]=digit3.
REQ-006 load  in  1  request to capture data_in.
REQ-007 ready  out  1  capture slot free; load accepted only when ready=1.
REQ-008 seg  out  7  segments {a,b,c,d,e,f,g}, active-high.
REQ-009 an  out  4  digit select, active-low, one-cold; an[i]=0 enables digit i.

Function
REQ-010 FSM states SHALL be IDLE (en=0) and SCAN (en=1); IDLE->SCAN when en=1, SCAN->IDLE when en=0, each taking effect the next cycle.
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 in SCAN, wrap to 0, and assert internal tick when count==CLK_DIV-1.
REQ-012 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 on tick; tick at idx=3 is the frame wrap.
REQ-013 In SCAN, an SHALL equal ~(4'b0001<<idx) and seg SHALL equal decode(shadow nibble idx), both registered, 1 cycle after idx/shadow change.
REQ-014 decode SHALL map 0..F to 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47 (hex, a=MSB).
REQ-015 In IDLE, an SHALL be 4'b1111, seg 7'h00, prescaler and idx held at 0.
REQ-016 load=1 with ready=1 SHALL capture data_in into pending register; ready SHALL be 0 the next cycle in SCAN.
REQ-017 load while ready=0 SHALL be ignored; pending unchanged.
REQ-018 At frame wrap, pending SHALL copy into shadow and ready SHALL return to 1 the next cycle; shadow never changes mid-frame.
REQ-019 In IDLE, an accepted load SHALL update shadow directly the next cycle; ready stays 1.
REQ-020 Load coincident with frame wrap while ready=0: commit existing pending, drop new load, ready=1 next cycle.
REQ-021 SCAN->IDLE with pending outstanding SHALL commit pending to shadow and set ready=1 on entering IDLE.
REQ-022 Load coincident with frame wrap while ready=1: new data captured to pending; ready=0 next cycle; commit at following wrap.

Reset
REQ-023 rst_n=0 at a clk edge SHALL force: state IDLE, prescaler 0, idx 0, shadow 0, pending 0, ready 1, an 4'b1111, seg 7'h00.
REQ-024 Reset SHALL override en and load in the same cycle, including mid-frame with pending outstanding (pending discarded).
REQ-025 First SCAN output after reset release with en=1 SHALL be digit 0 showing 7E (shadow=0).

Configuration
REQ-026 Macro SEG_SCAN_LZ_BLANK_EN defined: digits 3,2,1 SHALL output seg=7'h00 (an still driven) while that nibble and all higher nibbles are 0; digit 0 never blanked.
REQ-027 Macro undefined: every digit SHALL decode its nibble per REQ-014, zeros shown as 7E.

Verification (CLK_DIV=4)
REQ-028 Reset, en=1, no load -> an cycles 1110,1101,1011,0111 every 4 cycles, seg=7E throughout (7'h00 for digits 3..1 with LZ blank).
REQ-029 IDLE, load data_in=16'h1234 -> next cycle ready=1, shadow=1234; en=1 -> seg sequence 33,79,6D,30 for digits 0..3.
REQ-030 SCAN at idx=1, load 16'hABCD -> ready=0; second load 16'h0000 ignored; after idx=3 tick ready=1 and digit0 shows 3D, digit3 77.
REQ-031 Load 16'h0F00 in IDLE, macro defined -> digit3 seg=00, digit2 47, digit1 7E, digit0 7E; macro undefined -> digit3 7E.
REQ-032 en dropped at idx=2 with pending outstanding -> next cycle an=1111, seg=00, ready=1, shadow=pending; rst_n=0 mid-frame -> all REQ-023 values next cycle.
